// File: rtl/ahb_reg_access_arb.sv
// Round-robin arbiter that funnels register accesses from NUM_REQ local
// requesters onto the DMAC AHB slave configuration port. It runs one
// non-pipelined transfer at a time: address phase, then data phase, then a
// one-cycle response back to the winning requester. A per-phase watchdog
// aborts transfers that the slave never completes.
module ahb_reg_access_arb #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                  hclk,
    input  logic                  hrst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_hsel,
    output logic [AW-1:0]         m_haddr,
    output logic                  m_hwrite,
    output logic [1:0]            m_htrans,
    output logic [3:0]            m_hprot,
    output logic [DW-1:0]         m_hwdata,
    input  logic                  m_hready,
    input  logic [DW-1:0]         m_hrdata,
    input  logic [1:0]            m_hresp,
    output logic                  timeout_sticky
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One spare bit so the counter can never wrap before reaching TIMEOUT.
    localparam int CW = $clog2(TIMEOUT + 1) + 1;
    localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gnt;
    logic            lat_write;
    logic [DW-1:0]   lat_wdata;
    logic [CW-1:0]   wd_cnt;

    logic            any_req;
    logic [PW-1:0]   pick;
    logic            wd_expire;

    // (base + k) mod NUM_REQ without relying on NUM_REQ being a power of two.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    // Round-robin pick: first valid requester at or after rr_ptr, wrapping.
    // Walking downward lets the lowest offset overwrite the others.
    always_comb begin
        any_req = 1'b0;
        pick    = rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(rr_ptr, k)]) begin
                any_req = 1'b1;
                pick    = wrap_add(rr_ptr, k);
            end
        end
    end

    // The watchdog fires on the stalled edge that would bring wd_cnt to TIMEOUT.
    always_comb begin
        wd_expire = (TIMEOUT != 0) && !m_hready && (wd_cnt >= WD_LAST);
    end

    // Transfer sequencer: arbitration, AHB phases, response and watchdog.
    always_ff @(posedge hclk) begin
        if (!hrst_n) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            gnt            <= '0;
            lat_write      <= 1'b0;
            lat_wdata      <= '0;
            wd_cnt         <= '0;
            req_ready      <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            m_hsel         <= 1'b0;
            m_haddr        <= '0;
            m_hwrite       <= 1'b0;
            m_htrans       <= HTRANS_IDLE;
            m_hprot        <= HPROT_DATA;
            m_hwdata       <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            // Accept and completion strobes are single-cycle pulses.
            req_ready <= '0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt             <= pick;
                        rr_ptr          <= wrap_add(pick, 1);
                        lat_write       <= req_write[pick];
                        lat_wdata       <= req_wdata[int'(pick)*DW +: DW];
                        m_haddr         <= req_addr[int'(pick)*AW +: AW];
                        m_hwrite        <= req_write[pick];
                        m_hsel          <= 1'b1;
                        m_htrans        <= HTRANS_NONSEQ;
                        req_ready[pick] <= 1'b1;
                        wd_cnt          <= '0;
                        state           <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_hready) begin
                        m_hsel   <= 1'b0;
                        m_htrans <= HTRANS_IDLE;
                        m_hwrite <= 1'b0;
                        if (lat_write) m_hwdata <= lat_wdata;
                        wd_cnt   <= '0;
                        state    <= DATA;
                    end else if (wd_expire) begin
                        m_hsel         <= 1'b0;
                        m_htrans       <= HTRANS_IDLE;
                        m_hwrite       <= 1'b0;
                        rsp_err        <= 1'b1;
                        rsp_rdata      <= '0;
                        rsp_valid[gnt] <= 1'b1;
                        timeout_sticky <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (m_hready) begin
                        // Only the hready-high cycle of a two-cycle ERROR is sampled.
                        rsp_rdata      <= lat_write ? '0 : m_hrdata;
                        rsp_err        <= (m_hresp != 2'b00);
                        rsp_valid[gnt] <= 1'b1;
                        state          <= RESP;
                    end else if (wd_expire) begin
                        m_hsel         <= 1'b0;
                        m_htrans       <= HTRANS_IDLE;
                        rsp_err        <= 1'b1;
                        rsp_rdata      <= '0;
                        rsp_valid[gnt] <= 1'b1;
                        timeout_sticky <= 1'b1;
                        state          <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    // rsp_rdata/rsp_err keep their value until the next response.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_reg_access_arb.sv
// Bench for ahb_reg_access_arb: a transaction-timeline model predicts every
// output on every cycle, a scripted slave supplies wait states/errors, and
// directed tests pin the model with hand-computed literals.
module tb_ahb_reg_access_arb;

    localparam int NREQ = 2;
    localparam int TMO  = 64;

    logic             hclk, hrst_n;
    logic [NREQ-1:0]  req_valid, req_write;
    logic [NREQ*32-1:0] req_addr, req_wdata;
    logic [NREQ-1:0]  req_ready, rsp_valid;
    logic [31:0]      rsp_rdata;
    logic             rsp_err;
    logic             m_hsel, m_hwrite, m_hready, timeout_sticky;
    logic [31:0]      m_haddr, m_hwdata, m_hrdata;
    logic [1:0]       m_htrans, m_hresp;
    logic [3:0]       m_hprot;

    ahb_reg_access_arb #(.NUM_REQ(NREQ), .AW(32), .DW(32), .TIMEOUT(TMO)) dut (
        .hclk(hclk), .hrst_n(hrst_n),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_hsel(m_hsel), .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans),
        .m_hprot(m_hprot), .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hrdata(m_hrdata),
        .m_hresp(m_hresp), .timeout_sticky(timeout_sticky)
    );

    typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } req_t;
    typedef struct { int aw; int dw; bit err; } cfg_t;
    typedef struct {
        int g; bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rd;
        int aw; int dw; bit err; bit to; int t; int rsp;
    } xfer_t;
    typedef struct { int cyc; int idx; logic [31:0] rdata; logic err; } ev_t;

    req_t  rq [NREQ][$];
    cfg_t  cfg_q[$];
    ev_t   rdy_log[$];
    ev_t   rsp_log[$];
    logic [31:0] mem [logic [31:0]];

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    rr = 0;
    int    mg;
    bit    active = 0;
    xfer_t cur;
    cfg_t  cc;
    req_t  rr_req;
    logic [31:0] exp_rdata = '0, exp_hwdata = '0;
    logic  exp_err = 0, exp_sticky = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic bit busy();
        return active && (cyc <= cur.rsp + 1);
    endfunction

    initial begin
        hclk = 0;
        forever #5 hclk = ~hclk;
    end

    // Model: transaction timeline derived from arbitration edge and wait counts.
    initial forever begin
        @(posedge hclk);
        cyc++;
        if (!hrst_n) begin
            active = 0; rr = 0;
            exp_rdata = '0; exp_err = 0; exp_sticky = 0; exp_hwdata = '0;
        end else begin
            if (active && cyc > cur.rsp + 1) active = 0;
            if (active) begin
                if (cyc == cur.rsp) begin
                    exp_rdata = cur.to ? 32'h0 : (cur.wr ? 32'h0 : cur.rd);
                    exp_err   = cur.to ? 1'b1 : cur.err;
                    if (cur.to) exp_sticky = 1;
                end
                if (cur.wr && cur.aw < TMO && cyc == cur.t + 1 + cur.aw) exp_hwdata = cur.wdata;
            end
            if (!active && req_valid != '0) begin
                mg = -1;
                for (int k = 0; k < NREQ; k++)
                    if (mg < 0 && req_valid[(rr + k) % NREQ]) mg = (rr + k) % NREQ;
                rr = (mg + 1) % NREQ;
                rr_req = rq[mg].pop_front();
                cc = (cfg_q.size() > 0) ? cfg_q.pop_front() : '{0, 0, 1'b0};
                cur.g = mg; cur.wr = rr_req.wr; cur.addr = rr_req.addr; cur.wdata = rr_req.wdata;
                cur.rd = mem.exists(rr_req.addr) ? mem[rr_req.addr] : 32'hdeadbeef;
                cur.aw = cc.aw; cur.dw = cc.dw; cur.err = cc.err; cur.t = cyc;
                if (cc.aw >= TMO) begin cur.to = 1; cur.rsp = cyc + TMO; end
                else if (cc.dw >= TMO) begin cur.to = 1; cur.rsp = cyc + 1 + cc.aw + TMO; end
                else begin cur.to = 0; cur.rsp = cyc + 2 + cc.aw + cc.dw; end
                if (cur.wr && !cur.to) mem[cur.addr] = cur.wdata;
                active = 1;
            end
        end
    end

    // Per-cycle compare, event logging, then drive requesters and slave.
    initial forever begin
        bit hs;
        int a_end, d_end, e;
        @(negedge hclk);
        hs = active && cyc >= cur.t && cyc <= cur.t + cur.aw && cyc < cur.rsp;
        chk("req_ready", req_ready, (active && cyc == cur.t) ? (64'd1 << cur.g) : 64'd0);
        chk("rsp_valid", rsp_valid, (active && cyc == cur.rsp) ? (64'd1 << cur.g) : 64'd0);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", rsp_err, exp_err);
        chk("timeout_sticky", timeout_sticky, exp_sticky);
        chk("m_hsel", m_hsel, hs);
        chk("m_htrans", m_htrans, hs ? 2'b10 : 2'b00);
        chk("m_hwrite", m_hwrite, hs ? cur.wr : 1'b0);
        if (hs) chk("m_haddr", m_haddr, cur.addr);
        chk("m_hwdata", m_hwdata, exp_hwdata);
        chk("m_hprot", m_hprot, 4'b0011);
        if (req_ready != '0) rdy_log.push_back('{cyc, req_ready[1] ? 1 : 0, 32'h0, 1'b0});
        if (rsp_valid != '0) rsp_log.push_back('{cyc, rsp_valid[1] ? 1 : 0, rsp_rdata, rsp_err});
        for (int i = 0; i < NREQ; i++) begin
            if (rq[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_write[i] = rq[i][0].wr;
                req_addr[i*32 +: 32]  = rq[i][0].addr;
                req_wdata[i*32 +: 32] = rq[i][0].wdata;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        e = cyc + 1;
        m_hready = 1'b1; m_hresp = 2'b00; m_hrdata = 32'h12345678;
        if (active) begin
            a_end = cur.t + 1 + cur.aw;
            d_end = a_end + 1 + cur.dw;
            if (e > cur.t && e < a_end) m_hready = 1'b0;
            else if (e > a_end && e < d_end) begin
                m_hready = 1'b0; m_hresp = cur.err ? 2'b01 : 2'b00;
            end else if (e == d_end) begin
                m_hresp = cur.err ? 2'b01 : 2'b00; m_hrdata = cur.rd;
            end
        end
    end

    task automatic issue(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
        rq[i].push_back('{wr, a, d});
    endtask

    task automatic wait_idle(input int lim);
        int n = 0;
        while ((rq[0].size() != 0 || rq[1].size() != 0 || busy()) && n < lim) begin
            @(negedge hclk); #1; n++;
        end
        if (n >= lim) chk("idle_wait_expired", 1, 0);
    endtask

    task automatic do_reset();
        @(negedge hclk); #1; hrst_n = 0;
        @(negedge hclk); #1; hrst_n = 1;
    endtask

    initial begin
        int exp_g[4] = '{0, 1, 0, 1};
        int n;
        hrst_n = 0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        m_hready = 1; m_hresp = 0; m_hrdata = '0;
        repeat (2) @(negedge hclk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_hprot", m_hprot, 4'b0011);
        hrst_n = 1;

        // Test 1: write then read back, zero wait.
        rdy_log.delete(); rsp_log.delete();
        issue(0, 1, 32'h0, 32'h5a5a5a5a);
        wait_idle(50);
        issue(0, 0, 32'h0, 32'h0);
        wait_idle(50);
        chk("t1_nrsp", rsp_log.size(), 2);
        if (rsp_log.size() == 2 && rdy_log.size() == 2) begin
            chk("t1_wr_lat", rsp_log[0].cyc - rdy_log[0].cyc, 2);
            chk("t1_wr_idx", rsp_log[0].idx, 0);
            chk("t1_wr_err", rsp_log[0].err, 0);
            chk("t1_rd_data", rsp_log[1].rdata, 32'h5a5a5a5a);
        end

        // Test 2: both requesters continuously valid after reset.
        do_reset();
        rdy_log.delete(); rsp_log.delete();
        issue(0, 1, 32'h4, 32'hffff0000); issue(0, 0, 32'h4, 32'h0);
        issue(1, 1, 32'h8, 32'h0000ffff); issue(1, 0, 32'h8, 32'h0);
        wait_idle(80);
        chk("t2_nrsp", rsp_log.size(), 4);
        if (rsp_log.size() == 4) begin
            for (int k = 0; k < 4; k++) chk("t2_grant", rsp_log[k].idx, exp_g[k]);
            for (int k = 1; k < 4; k++) chk("t2_spacing", rsp_log[k].cyc - rsp_log[k-1].cyc, 4);
            chk("t2_rd0", rsp_log[2].rdata, 32'hffff0000);
            chk("t2_rd1", rsp_log[3].rdata, 32'h0000ffff);
        end

        // Test 3: 3 address-phase and 2 data-phase wait states.
        rdy_log.delete(); rsp_log.delete();
        cfg_q.push_back('{3, 2, 1'b0});
        issue(1, 0, 32'h8, 32'h0);
        wait_idle(50);
        chk("t3_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() == 1 && rdy_log.size() == 1) begin
            chk("t3_lat", rsp_log[0].cyc - rdy_log[0].cyc, 7);
            chk("t3_data", rsp_log[0].rdata, 32'h0000ffff);
        end

        // Test 4: two-cycle ERROR response.
        rdy_log.delete(); rsp_log.delete();
        cfg_q.push_back('{0, 1, 1'b1});
        issue(0, 0, 32'h100, 32'h0);
        wait_idle(50);
        chk("t4_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() == 1 && rdy_log.size() == 1) begin
            chk("t4_err", rsp_log[0].err, 1);
            chk("t4_lat", rsp_log[0].cyc - rdy_log[0].cyc, 3);
        end
        chk("t4_sticky", timeout_sticky, 0);

        // Test 5: slave stalls forever in data phase, then normal traffic.
        rdy_log.delete(); rsp_log.delete();
        cfg_q.push_back('{0, 1000, 1'b0});
        issue(0, 0, 32'h0, 32'h0);
        wait_idle(200);
        chk("t5_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() == 1 && rdy_log.size() == 1) begin
            chk("t5_lat", rsp_log[0].cyc - rdy_log[0].cyc, 65);
            chk("t5_err", rsp_log[0].err, 1);
            chk("t5_rdata", rsp_log[0].rdata, 0);
        end
        chk("t5_sticky", timeout_sticky, 1);
        issue(1, 1, 32'hc, 32'h13572468); issue(1, 0, 32'hc, 32'h0);
        wait_idle(50);
        chk("t5_nrsp2", rsp_log.size(), 3);
        if (rsp_log.size() == 3) begin
            chk("t5_after_err", rsp_log[2].err, 0);
            chk("t5_after_data", rsp_log[2].rdata, 32'h13572468);
        end

        // Test 6: reset while req0 sits in the data phase, req1 waiting.
        rdy_log.delete(); rsp_log.delete();
        cfg_q.push_back('{0, 5, 1'b0});
        issue(0, 0, 32'h4, 32'h0);
        n = 0;
        while (rdy_log.size() == 0 && n < 20) begin @(negedge hclk); #1; n++; end
        if (n >= 20) chk("t6_grant_wait_expired", 1, 0);
        issue(1, 0, 32'h8, 32'h0);
        @(negedge hclk); #1;
        hrst_n = 0;
        @(negedge hclk); #1;
        chk("t6_hsel", m_hsel, 0);
        chk("t6_htrans", m_htrans, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_req_ready", req_ready, 0);
        chk("t6_hprot", m_hprot, 4'b0011);
        chk("t6_sticky", timeout_sticky, 0);
        hrst_n = 1;
        wait_idle(50);
        chk("t6_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() == 1) begin
            chk("t6_rsp_idx", rsp_log[0].idx, 1);
            chk("t6_rsp_data", rsp_log[0].rdata, 32'h0000ffff);
        end
        chk("t6_nrdy", rdy_log.size(), 2);
        if (rdy_log.size() == 2) chk("t6_first_after_rst", rdy_log[1].idx, 1);

        repeat (3) @(negedge hclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

endmodule
